// File: rtl/dbg_trace_buf_if.sv
// Retirement debug bus from the single-cycle RV32I core into the trace buffer.
interface dbg_trace_buf_if;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic [31:0] in_wd;

  modport master (
    output in_pc, in_instr, in_rd, in_reg_write, in_wd
  );

  modport slave (
    input in_pc, in_instr, in_rd, in_reg_write, in_wd
  );
endinterface

// File: rtl/dbg_trace_buf.sv
// Circular retirement-trace buffer with PC trigger, post-trigger depth and
// oldest-first indexed readback once capture has frozen.
module dbg_trace_buf #(
  parameter int DEPTH       = 16,
  parameter bit CAPTURE_ALL = 1'b0,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  dbg_trace_buf_if.slave    core,
  input  logic              arm,
  input  logic              trig_en,
  input  logic [31:0]       trig_pc,
  input  logic [AW-1:0]     post_len,
  output logic              busy,
  output logic              triggered,
  output logic              done,
  output logic [AW:0]       count,
  input  logic [AW-1:0]     rd_idx,
  output logic              rd_valid,
  output logic [31:0]       rd_pc,
  output logic [31:0]       rd_instr,
  output logic [4:0]        rd_rd,
  output logic [31:0]       rd_wd
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

  logic [1:0]    state;
  logic [AW-1:0] wp;
  logic [AW:0]   cnt;
  logic [AW-1:0] remain;
  logic          trig_q;
  logic          trig_en_q;
  logic [31:0]   trig_pc_q;
  logic [AW-1:0] post_len_q;

  logic [100:0]  mem [DEPTH];

  logic          qual;
  logic          cap;
  logic          full;
  logic [AW-1:0] oldest;
  logic [AW-1:0] raddr;

  always_comb begin
    qual   = CAPTURE_ALL || (core.in_reg_write && (core.in_rd != '0));
    cap    = ((state == S_ARMED) || (state == S_POST)) && qual;
    full   = (cnt == FULL);
    oldest = full ? wp : '0;
    raddr  = oldest + rd_idx;
  end

  // The arm cycle and reset cycle never write, even if a retirement is present.
  always_ff @(posedge clk) begin
    if (cap && !rst && !arm)
      mem[wp] <= {core.in_pc, core.in_instr, core.in_rd, core.in_wd};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wp         <= '0;
      cnt        <= '0;
      remain     <= '0;
      trig_q     <= 1'b0;
      trig_en_q  <= 1'b0;
      trig_pc_q  <= '0;
      post_len_q <= '0;
    end else if (arm) begin
      state      <= S_ARMED;
      wp         <= '0;
      cnt        <= '0;
      trig_q     <= 1'b0;
      trig_en_q  <= trig_en;
      trig_pc_q  <= trig_pc;
      post_len_q <= post_len;
    end else if (cap) begin
      wp <= wp + AW'(1);
      if (!full)
        cnt <= cnt + (AW+1)'(1);
      case (state)
        S_ARMED: begin
          if (trig_en_q) begin
            if (core.in_pc == trig_pc_q) begin
              trig_q <= 1'b1;
              if (post_len_q == '0) begin
                state <= S_DONE;
              end else begin
                state  <= S_POST;
                remain <= post_len_q;
              end
            end
          end else if (cnt == LAST) begin
            state <= S_DONE;
          end
        end
        S_POST: begin
          remain <= remain - AW'(1);
          if (remain == AW'(1))
            state <= S_DONE;
        end
        default: ;
      endcase
    end
  end

  // Read port sees pre-edge memory, so a same-edge overwrite returns old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_pc    <= '0;
      rd_instr <= '0;
      rd_rd    <= '0;
      rd_wd    <= '0;
    end else begin
      rd_valid <= ({1'b0, rd_idx} < cnt);
      {rd_pc, rd_instr, rd_rd, rd_wd} <= mem[raddr];
    end
  end

  always_comb begin
    busy      = (state == S_ARMED) || (state == S_POST);
    done      = (state == S_DONE);
    triggered = trig_q;
    count     = cnt;
  end

endmodule

// File: tb/tb_dbg_trace_buf.sv
// Bench for dbg_trace_buf: three configurations share one stimulus stream and
// are checked every cycle against a queue-based model plus literal expectations.
module tb_dbg_trace_buf;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm;
  logic        trig_en;
  logic [31:0] trig_pc;
  logic [3:0]  post_len;
  logic [3:0]  rd_idx;

  dbg_trace_buf_if tif();

  logic        busy_o [3];
  logic        trig_o [3];
  logic        done_o [3];
  logic        rdv_o  [3];
  logic [31:0] rpc_o  [3];
  logic [31:0] rins_o [3];
  logic [4:0]  rrd_o  [3];
  logic [31:0] rwd_o  [3];
  logic [4:0]  c0;
  logic [2:0]  c1;
  logic [3:0]  c2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dbg_trace_buf #(.DEPTH(16), .CAPTURE_ALL(1'b0)) u_d0 (
    .clk(clk), .rst(rst), .core(tif.slave), .arm(arm), .trig_en(trig_en),
    .trig_pc(trig_pc), .post_len(post_len[3:0]), .busy(busy_o[0]),
    .triggered(trig_o[0]), .done(done_o[0]), .count(c0), .rd_idx(rd_idx[3:0]),
    .rd_valid(rdv_o[0]), .rd_pc(rpc_o[0]), .rd_instr(rins_o[0]),
    .rd_rd(rrd_o[0]), .rd_wd(rwd_o[0])
  );

  dbg_trace_buf #(.DEPTH(4), .CAPTURE_ALL(1'b0)) u_d1 (
    .clk(clk), .rst(rst), .core(tif.slave), .arm(arm), .trig_en(trig_en),
    .trig_pc(trig_pc), .post_len(post_len[1:0]), .busy(busy_o[1]),
    .triggered(trig_o[1]), .done(done_o[1]), .count(c1), .rd_idx(rd_idx[1:0]),
    .rd_valid(rdv_o[1]), .rd_pc(rpc_o[1]), .rd_instr(rins_o[1]),
    .rd_rd(rrd_o[1]), .rd_wd(rwd_o[1])
  );

  dbg_trace_buf #(.DEPTH(8), .CAPTURE_ALL(1'b1)) u_d2 (
    .clk(clk), .rst(rst), .core(tif.slave), .arm(arm), .trig_en(trig_en),
    .trig_pc(trig_pc), .post_len(post_len[2:0]), .busy(busy_o[2]),
    .triggered(trig_o[2]), .done(done_o[2]), .count(c2), .rd_idx(rd_idx[2:0]),
    .rd_valid(rdv_o[2]), .rd_pc(rpc_o[2]), .rd_instr(rins_o[2]),
    .rd_rd(rrd_o[2]), .rd_wd(rwd_o[2])
  );

  function automatic int unsigned dep(int d);
    case (d)
      0:       return 16;
      1:       return 4;
      default: return 8;
    endcase
  endfunction

  function automatic bit cap_all(int d);
    return (d == 2);
  endfunction

  function automatic logic [31:0] got_cnt(int d);
    case (d)
      0:       return 32'(c0);
      1:       return 32'(c1);
      default: return 32'(c2);
    endcase
  endfunction

  task automatic chk(string nm, int d, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h, want %h at %0t", nm, d, got, want, $time);
    end
  endtask

  // Model: each buffer is an oldest-first queue trimmed to its depth.
  ent_t        mq [3][$];
  bit          m_run  [3];
  bit          m_frz  [3];
  bit          m_post [3];
  bit          m_trig [3];
  bit          m_ten  [3];
  logic [31:0] m_tpc  [3];
  int unsigned m_plen [3];
  int unsigned m_rem  [3];
  bit          e_valid [3];
  bit          e_chk   [3];
  ent_t        e_ent   [3];
  bit          m_live = 1'b0;

  initial begin
    ent_t        cur;
    int unsigned idx;
    bit          qual;
    bit          cap;
    forever begin
      @(posedge clk);
      cur = {tif.in_pc, tif.in_instr, tif.in_rd, tif.in_wd};
      for (int d = 0; d < 3; d++) begin
        idx  = 32'(rd_idx) % dep(d);
        qual = cap_all(d) || (tif.in_reg_write && (tif.in_rd != 5'd0));
        cap  = m_run[d] && qual && !rst && !arm;
        e_valid[d] = (idx < mq[d].size());
        e_chk[d]   = e_valid[d] && !(cap && (mq[d].size() == dep(d)) && (idx == 0));
        if (e_valid[d])
          e_ent[d] = mq[d][idx];
        if (rst) begin
          mq[d].delete();
          m_run[d] = 0; m_frz[d] = 0; m_post[d] = 0; m_trig[d] = 0;
          e_valid[d] = 0; e_chk[d] = 1; e_ent[d] = '0;
          m_live = 1'b1;
        end else if (arm) begin
          mq[d].delete();
          m_run[d] = 1; m_frz[d] = 0; m_post[d] = 0; m_trig[d] = 0;
          m_ten[d]  = trig_en;
          m_tpc[d]  = trig_pc;
          m_plen[d] = 32'(post_len) % dep(d);
        end else if (cap) begin
          mq[d].push_back(cur);
          if (mq[d].size() > dep(d))
            mq[d].delete(0);
          if (m_post[d]) begin
            m_rem[d]--;
            if (m_rem[d] == 0) begin
              m_run[d] = 0; m_post[d] = 0; m_frz[d] = 1;
            end
          end else if (m_ten[d]) begin
            if (tif.in_pc == m_tpc[d]) begin
              m_trig[d] = 1;
              if (m_plen[d] == 0) begin
                m_run[d] = 0; m_frz[d] = 1;
              end else begin
                m_post[d] = 1; m_rem[d] = m_plen[d];
              end
            end
          end else if (mq[d].size() == dep(d)) begin
            m_run[d] = 0; m_frz[d] = 1;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        for (int d = 0; d < 3; d++) begin
          chk("busy", d, busy_o[d], m_run[d]);
          chk("triggered", d, trig_o[d], m_trig[d]);
          chk("done", d, done_o[d], m_frz[d]);
          chk("count", d, got_cnt(d), mq[d].size());
          chk("rd_valid", d, rdv_o[d], e_valid[d]);
          if (e_chk[d]) begin
            chk("rd_pc", d, rpc_o[d], e_ent[d].pc);
            chk("rd_instr", d, rins_o[d], e_ent[d].instr);
            chk("rd_rd", d, rrd_o[d], e_ent[d].rd);
            chk("rd_wd", d, rwd_o[d], e_ent[d].wd);
          end
        end
      end
    end
  end

  task automatic retire(logic [31:0] pc, logic [31:0] ins, logic [4:0] rd,
                        logic rw, logic [31:0] wd);
    tif.in_pc = pc; tif.in_instr = ins; tif.in_rd = rd;
    tif.in_reg_write = rw; tif.in_wd = wd;
    @(negedge clk);
  endtask

  task automatic idle();
    tif.in_reg_write = 1'b0;
    tif.in_rd = 5'd0;
  endtask

  task automatic do_arm(logic ten, logic [31:0] tpc, logic [3:0] pl);
    arm = 1'b1; trig_en = ten; trig_pc = tpc; post_len = pl;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic rd_chk(int d, int idx, bit v, logic [31:0] pc, logic [4:0] rd,
                        logic [31:0] wd);
    rd_idx = 4'(idx);
    @(negedge clk);
    chk("lit_rd_valid", d, rdv_o[d], v);
    if (v) begin
      chk("lit_rd_pc", d, rpc_o[d], pc);
      chk("lit_rd_rd", d, rrd_o[d], rd);
      chk("lit_rd_wd", d, rwd_o[d], wd);
    end
  endtask

  task automatic program4();
    retire(32'h0, 32'h00500093, 5'd1, 1'b1, 32'd5);
    retire(32'h4, 32'h00800113, 5'd2, 1'b1, 32'd8);
    retire(32'h8, 32'h002081B3, 5'd3, 1'b1, 32'd13);
    retire(32'hC, 32'h4011D213, 5'd4, 1'b1, 32'd6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; arm = 1'b0; trig_en = 1'b0; trig_pc = '0; post_len = '0;
    rd_idx = '0;
    tif.in_pc = '0; tif.in_instr = '0; tif.in_rd = '0;
    tif.in_reg_write = 1'b0; tif.in_wd = '0;
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_busy", d, busy_o[d], 0);
      chk("rst_done", d, done_o[d], 0);
      chk("rst_count", d, got_cnt(d), 0);
      chk("rst_rd_valid", d, rdv_o[d], 0);
      chk("rst_rd_pc", d, rpc_o[d], 0);
    end
    rst = 1'b0;

    // Stop-when-full mode, partial fill.
    do_arm(1'b0, 32'h0, 4'd0);
    chk("arm_busy", 0, busy_o[0], 1);
    program4();
    idle();
    chk("p1_count", 0, got_cnt(0), 4);
    chk("p1_busy", 0, busy_o[0], 1);
    chk("p1_done", 0, done_o[0], 0);
    chk("p1_d1_done", 1, done_o[1], 1);
    rd_chk(0, 0, 1, 32'h0, 5'd1, 32'd5);
    rd_chk(0, 1, 1, 32'h4, 5'd2, 32'd8);
    rd_chk(0, 2, 1, 32'h8, 5'd3, 32'd13);
    rd_chk(0, 3, 1, 32'hC, 5'd4, 32'd6);
    rd_chk(0, 4, 0, 32'h0, 5'd0, 32'd0);

    // PC trigger with one post-trigger entry.
    do_arm(1'b1, 32'h4, 4'd1);
    retire(32'h0, 32'h00500093, 5'd1, 1'b1, 32'd5);
    retire(32'h4, 32'h00800113, 5'd2, 1'b1, 32'd8);
    chk("p2_trig", 0, trig_o[0], 1);
    chk("p2_done_early", 0, done_o[0], 0);
    retire(32'h8, 32'h002081B3, 5'd3, 1'b1, 32'd13);
    chk("p2_done", 0, done_o[0], 1);
    chk("p2_count", 0, got_cnt(0), 3);
    retire(32'hC, 32'h4011D213, 5'd4, 1'b1, 32'd6);
    idle();
    chk("p2_count_frozen", 0, got_cnt(0), 3);
    rd_chk(0, 0, 1, 32'h0, 5'd1, 32'd5);
    rd_chk(0, 1, 1, 32'h4, 5'd2, 32'd8);
    rd_chk(0, 2, 1, 32'h8, 5'd3, 32'd13);
    rd_chk(0, 3, 0, 32'h0, 5'd0, 32'd0);

    // Wrap in a 4-deep buffer, trigger on the last write.
    do_arm(1'b1, 32'h24, 4'd0);
    for (int i = 0; i < 10; i++)
      retire(32'(i * 4), 32'h13, 5'(i + 1), 1'b1, 32'(i * 3));
    idle();
    chk("p3_done", 1, done_o[1], 1);
    chk("p3_count", 1, got_cnt(1), 4);
    chk("p3_d0_count", 0, got_cnt(0), 10);
    for (int k = 0; k < 4; k++)
      rd_chk(1, k, 1, 32'(32'h18 + k * 4), 5'(k + 7), 32'((k + 6) * 3));

    // Qualification: skipped cycles vs capture-every-cycle.
    do_arm(1'b0, 32'h0, 4'd0);
    retire(32'h100, 32'h13, 5'd1, 1'b1, 32'h11);
    retire(32'h104, 32'h13, 5'd2, 1'b0, 32'h22);
    retire(32'h108, 32'h13, 5'd0, 1'b1, 32'h33);
    retire(32'h10C, 32'h13, 5'd5, 1'b1, 32'h55);
    idle();
    chk("p4_count_filt", 0, got_cnt(0), 2);
    chk("p4_count_all", 2, got_cnt(2), 4);
    rd_chk(0, 1, 1, 32'h10C, 5'd5, 32'h55);
    rd_chk(2, 1, 1, 32'h104, 5'd2, 32'h22);
    rd_chk(0, 2, 0, 32'h0, 5'd0, 32'd0);

    // Re-arm while in the post-trigger phase.
    do_arm(1'b1, 32'h210, 4'd5);
    for (int i = 0; i < 5; i++)
      retire(32'(32'h200 + i * 4), 32'h13, 5'(i + 1), 1'b1, 32'(i));
    chk("p5_trig", 0, trig_o[0], 1);
    chk("p5_count", 0, got_cnt(0), 5);
    chk("p5_busy", 0, busy_o[0], 1);
    tif.in_pc = 32'h300; tif.in_rd = 5'd7; tif.in_reg_write = 1'b1; tif.in_wd = 32'h77;
    do_arm(1'b0, 32'h0, 4'd0);
    chk("p5_rearm_count", 0, got_cnt(0), 0);
    chk("p5_rearm_trig", 0, trig_o[0], 0);
    chk("p5_rearm_busy", 0, busy_o[0], 1);
    retire(32'h304, 32'h13, 5'd8, 1'b1, 32'h88);
    idle();
    chk("p5_resume_count", 0, got_cnt(0), 1);
    rd_chk(0, 0, 1, 32'h304, 5'd8, 32'h88);

    // Reset in the middle of capture.
    do_arm(1'b0, 32'h0, 4'd0);
    for (int i = 0; i < 3; i++)
      retire(32'(32'h400 + i * 4), 32'h13, 5'(i + 1), 1'b1, 32'(i + 1));
    chk("p6_count", 0, got_cnt(0), 3);
    rd_idx = 4'd0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk("p6_rst_count", d, got_cnt(d), 0);
      chk("p6_rst_busy", d, busy_o[d], 0);
      chk("p6_rst_trig", d, trig_o[d], 0);
      chk("p6_rst_done", d, done_o[d], 0);
      chk("p6_rst_rd_valid", d, rdv_o[d], 0);
      chk("p6_rst_rd_pc", d, rpc_o[d], 0);
    end
    retire(32'h40C, 32'h13, 5'd9, 1'b1, 32'h9);
    retire(32'h410, 32'h13, 5'd10, 1'b1, 32'hA);
    idle();
    chk("p6_no_cap", 0, got_cnt(0), 0);
    chk("p6_no_cap_all", 2, got_cnt(2), 0);
    chk("p6_idle_busy", 0, busy_o[0], 0);

    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dbg_trace_buf.md
# dbg_trace_buf

Parametrised retirement-trace capture buffer for the single-cycle RV32I core. It attaches to the core's debug outputs (`dbg_pc`, `dbg_instr`, `dbg_rd`, `dbg_reg_write`, `dbg_wd`) and records retired instructions into a circular buffer, with an optional PC-match trigger and programmable post-trigger depth. After capture stops, the buffer freezes and is read back by index, oldest entry first. It replaces end-of-run `$display` checking with in-design, bench-readable write history.

## Interface
Parameters:
- `DEPTH`, 16, number of entries; power of two, ≥ 2
- `CAPTURE_ALL`, 0, 0 = capture only cycles with `in_reg_write`=1 and `in_rd`≠0; 1 = capture every cycle
- Derived: `AW` = $clog2(DEPTH)

Ports (clock is `clk`; reset is `rst`, synchronous, active-high):
- `clk` in 1: clock
- `rst` in 1: synchronous active-high reset
- `in_pc` in 32: core `dbg_pc`
- `in_instr` in 32: core `dbg_instr`
- `in_rd` in 5: core `dbg_rd`
- `in_reg_write` in 1: core `dbg_reg_write`
- `in_wd` in 32: core `dbg_wd`
- `arm` in 1: single-cycle pulse that clears the buffer and starts capture
- `trig_en` in 1: 1 = stop on PC trigger; 0 = stop when full; latched on `arm`
- `trig_pc` in 32: trigger PC; latched on `arm`
- `post_len` in AW: entries captured after the trigger entry; latched on `arm`
- `busy` out 1: state is ARMED or POST
- `triggered` out 1: trigger entry has been captured since the last `arm`
- `done` out 1: state is DONE
- `count` out AW+1: valid entries, saturates at DEPTH
- `rd_idx` in AW: read index; 0 = oldest entry
- `rd_valid` out 1: registered; `rd_idx` < `count`
- `rd_pc`, `rd_instr`, `rd_wd` out 32 each: registered entry fields
- `rd_rd` out 5: registered entry field

## Operation
- Entry = {pc, instr, rd, wd} (101 bits). Storage is DEPTH-entry memory with write pointer `wp` (AW bits, wraps modulo DEPTH).
- Capture event `cap` = state ∈ {ARMED, POST} and (CAPTURE_ALL or (`in_reg_write` and `in_rd`≠0)).
- On `cap`: write entry at `wp`, then `wp`+1 and `count` = min(`count`+1, DEPTH).
- States:
  - IDLE: reset state; no capture.
  - ARMED: circular capture. With `trig_en`=1, a `cap` whose `in_pc`==latched `trig_pc` sets `triggered`; the next state is DONE if `post_len`==0, otherwise POST with `remain`=`post_len`. With `trig_en`=0, go to DONE on the `cap` that makes `count`==DEPTH.
  - POST: each `cap` decrements `remain`; the `cap` that takes it to 0 moves to DONE.
  - DONE: frozen; memory, `count` and `triggered` are held.
- `arm` from any state: `wp`←0, `count`←0, `triggered`←0, latch `trig_en`/`trig_pc`/`post_len`, go to ARMED. The arm cycle itself is never captured. `rst` overrides `arm`.
- ARMED with `trig_en`=1 never stops on its own. It overwrites the oldest entry after wrap and keeps `count`=DEPTH.
- Readback (valid in any state; the bench reads it in DONE):
  - oldest = (`count`==DEPTH) ? `wp` : 0
  - physical address = (oldest + `rd_idx`) mod DEPTH
  - `rd_valid`=0 when `rd_idx` ≥ `count`; the data fields are then don't-care.

## Timing
- Reset values: state IDLE, `wp`=0, `count`=0, `busy`=0, `triggered`=0, `done`=0, `rd_valid`=0, all `rd_*` data = 0. Memory contents are not reset.
- Capture samples the `in_*` signals at the rising edge of `clk`. The entry is readable, and `count` is updated, after that edge.
- `done` rises on the edge that writes the final entry, so it is visible in the cycle after the final retiring instruction.
- `busy` rises on the edge that samples `arm`=1.
- Read latency is 1 cycle: `rd_idx` presented in cycle N gives `rd_*` valid in cycle N+1.
- When a read hits an entry being written on the same edge, old data is returned. The bench must not depend on this case.

## Test plan
- Program addi x1,5 / addi x2,8 / add x3 / srai x4; `arm` after reset, `trig_en`=0, `CAPTURE_ALL`=0, DEPTH=16 -> after 4 retires `count`=4, `busy`=1, `done`=0. Reads give idx0 {pc 0, rd 1, wd 5}, idx1 {4, 2, 8}, idx2 {8, 3, 13}, idx3 {12, 4, 6}; idx4 gives `rd_valid`=0.
- Same program, `trig_en`=1, `trig_pc`=4, `post_len`=1 -> `triggered` after pc 4, `done` after pc 8, `count`=3, entries pc 0/4/8. A later write at pc 12 is not captured.
- DEPTH=4, `trig_en`=1, `trig_pc`=0x24, `post_len`=0, 10 writes at pc 0..0x24 -> `done` after pc 0x24, `count`=4; idx0..3 give pc 0x18/0x1C/0x20/0x24 (wrap, oldest-first).
- `CAPTURE_ALL`=1 with a cycle where `in_reg_write`=0 -> that cycle is still captured. With `CAPTURE_ALL`=0, writes to x0 and non-writing cycles are skipped.
- `arm` pulsed while in POST with `count`=5 -> next cycle `count`=0, `triggered`=0, state ARMED; capture resumes the cycle after.
- `rst` asserted in ARMED with `count`=3 -> next cycle all outputs at their reset values, state IDLE, and no capture until the next `arm`.
